// File: rtl/circle_pkg.sv
// Shared types for the circle engine: FSM/mode/span encodings and the
// outline octant order expressed as swap/sign bits.
package circle_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    typedef enum logic {OUTLINE, FILLED} mode_t;
    typedef enum logic [1:0] {SPAN_A, SPAN_B, SPAN_C, SPAN_D} span_t;

    typedef struct packed {
        logic swap;   // use (oy, ox) instead of (ox, oy)
        logic neg_x;
        logic neg_y;
    } octant_t;

    function automatic octant_t octant_lookup(input logic [2:0] idx);
        octant_t o;
        o = '0;
        case (idx)
            3'd0: o = '{swap: 1'b0, neg_x: 1'b0, neg_y: 1'b0};
            3'd1: o = '{swap: 1'b1, neg_x: 1'b0, neg_y: 1'b0};
            3'd2: o = '{swap: 1'b0, neg_x: 1'b1, neg_y: 1'b0};
            3'd3: o = '{swap: 1'b1, neg_x: 1'b1, neg_y: 1'b0};
            3'd4: o = '{swap: 1'b0, neg_x: 1'b1, neg_y: 1'b1};
            3'd5: o = '{swap: 1'b1, neg_x: 1'b1, neg_y: 1'b1};
            3'd6: o = '{swap: 1'b0, neg_x: 1'b0, neg_y: 1'b1};
            default: o = '{swap: 1'b1, neg_x: 1'b0, neg_y: 1'b1};
        endcase
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/circle_pixel_clip.sv
// Combinational screen-bounds check for a signed pixel coordinate; also
// hands back the coordinate truncated to the VGA port widths.
module circle_pixel_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 10
) (
    input  logic signed [C_W-1:0] x_i,
    input  logic signed [C_W-1:0] y_i,
    output logic        [X_W-1:0] x_o,
    output logic        [Y_W-1:0] y_o,
    output logic                  in_bounds_o
);

    localparam logic signed [C_W-1:0] W_LIM = C_W'(SCREEN_W);
    localparam logic signed [C_W-1:0] H_LIM = C_W'(SCREEN_H);

    assign x_o = x_i[X_W-1:0];
    assign y_o = y_i[Y_W-1:0];
    assign in_bounds_o = !x_i[C_W-1] && (x_i < W_LIM) &&
                         !y_i[C_W-1] && (y_i < H_LIM);

endmodule

// File: rtl/circle_draw_param.sv
// Midpoint circle engine, outline or filled, one clipped pixel per clock,
// registered outputs feeding the VGA adapter.
module circle_draw_param
    import circle_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    input  logic [COLOUR_W-1:0] colour,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int C_W = max3(X_W, Y_W, R_W) + 2;
    localparam int K_W = R_W + 3;
    typedef logic signed [C_W-1:0] coord_t;
    typedef logic signed [K_W-1:0] crit_t;

    state_t  state_q, state_d;
    mode_t   mode_q, mode_d;
    coord_t  cx_q, cx_d, cy_q, cy_d;
    coord_t  ox_q, ox_d, oy_q, oy_d, xoff_q, xoff_d;
    crit_t   crit_q, crit_d;
    logic [2:0] oct_q, oct_d;
    span_t   span_q, span_d;
    logic    fin_q, fin_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, vcol_q, vcol_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic    plot_q, plot_d, done_q, done_d;

    octant_t oct;
    coord_t  oct_a, oct_b, ext, px, py, ox_n, oy_n;
    crit_t   crit_n;
    logic    last_px, cont;
    logic [X_W-1:0] clip_x;
    logic [Y_W-1:0] clip_y;
    logic    clip_in;

    circle_pixel_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .C_W      (C_W)
    ) u_clip (
        .x_i         (px),
        .y_i         (py),
        .x_o         (clip_x),
        .y_o         (clip_y),
        .in_bounds_o (clip_in)
    );

    // Current pixel and end-of-iteration update, derived from the counters
    always_comb begin
        oct   = octant_lookup(oct_q);
        oct_a = oct.swap ? oy_q : ox_q;
        oct_b = oct.swap ? ox_q : oy_q;
        ext   = (span_q == SPAN_A || span_q == SPAN_B) ? ox_q : oy_q;
        if (mode_q == FILLED) begin
            px = cx_q + xoff_q;
            py = cy_q + oy_q;
            case (span_q)
                SPAN_A:  py = cy_q + oy_q;
                SPAN_B:  py = cy_q - oy_q;
                SPAN_C:  py = cy_q + ox_q;
                default: py = cy_q - ox_q;
            endcase
            last_px = (span_q == SPAN_D) && (xoff_q == ext);
        end else begin
            px = oct.neg_x ? cx_q - oct_a : cx_q + oct_a;
            py = oct.neg_y ? cy_q - oct_b : cy_q + oct_b;
            last_px = (oct_q == 3'd7);
        end
        oy_n = oy_q + coord_t'(1);
        if (crit_q <= crit_t'(0)) begin
            ox_n   = ox_q;
            crit_n = crit_q + (crit_t'(oy_n) <<< 1) + crit_t'(1);
        end else begin
            ox_n   = ox_q - coord_t'(1);
            crit_n = crit_q + ((crit_t'(oy_n) - crit_t'(ox_n)) <<< 1) + crit_t'(1);
        end
        cont = (oy_n <= ox_n);
    end

    always_comb begin
        state_d  = state_q;  mode_d  = mode_q;  cx_d   = cx_q;   cy_d = cy_q;
        colour_d = colour_q; ox_d    = ox_q;    oy_d   = oy_q;   crit_d = crit_q;
        oct_d    = oct_q;    span_d  = span_q;  xoff_d = xoff_q; fin_d = fin_q;
        x_d      = x_q;      y_d     = y_q;     vcol_d = vcol_q;
        plot_d   = 1'b0;     done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    mode_d   = mode_t'(mode);
                    cx_d     = coord_t'(centre_x);
                    cy_d     = coord_t'(centre_y);
                    colour_d = colour;
                    ox_d     = coord_t'(radius);
                    oy_d     = '0;
                    crit_d   = crit_t'(1) - crit_t'(radius);
                    oct_d    = '0;
                    span_d   = SPAN_A;
                    xoff_d   = -coord_t'(radius);
                    fin_d    = 1'b0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                // fin_q spends one idle cycle so done rises the cycle after the last pixel
                if (fin_q) begin
                    fin_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d    = clip_x;
                    y_d    = clip_y;
                    plot_d = clip_in;
                    vcol_d = colour_q;
                    if (last_px) begin
                        ox_d   = ox_n;
                        oy_d   = oy_n;
                        crit_d = crit_n;
                        oct_d  = '0;
                        span_d = SPAN_A;
                        xoff_d = -ox_n;
                        fin_d  = !cont;
                    end else if (mode_q == FILLED) begin
                        if (xoff_q != ext) begin
                            xoff_d = xoff_q + coord_t'(1);
                        end else begin
                            span_d = span_t'(span_q + 2'd1);
                            xoff_d = (span_q == SPAN_A) ? -ox_q : -oy_q;
                        end
                    end else begin
                        oct_d = oct_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;   mode_q  <= OUTLINE; cx_q   <= '0; cy_q  <= '0;
            colour_q <= '0;     ox_q    <= '0;      oy_q   <= '0; crit_q <= '0;
            oct_q    <= '0;     span_q  <= SPAN_A;  xoff_q <= '0; fin_q <= 1'b0;
            x_q      <= '0;     y_q     <= '0;      vcol_q <= '0;
            plot_q   <= 1'b0;   done_q  <= 1'b0;
        end else begin
            state_q  <= state_d;  mode_q  <= mode_d;  cx_q   <= cx_d;   cy_q  <= cy_d;
            colour_q <= colour_d; ox_q    <= ox_d;    oy_q   <= oy_d;   crit_q <= crit_d;
            oct_q    <= oct_d;    span_q  <= span_d;  xoff_q <= xoff_d; fin_q <= fin_d;
            x_q      <= x_d;      y_q     <= y_d;     vcol_q <= vcol_d;
            plot_q   <= plot_d;   done_q  <= done_d;
        end
    end

    assign done       = done_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = vcol_q;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_circle_draw_param.sv
// Directed bench for circle_draw_param: default 160x120 instance plus a
// 320x240 instance for the wider-screen clipping case.
module tb_circle_draw_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start1 = 1'b0, start2 = 1'b0, mode = 1'b0;
    logic [8:0] cx = '0;
    logic [7:0] cy = '0;
    logic [7:0] radius = '0;
    logic [2:0] colour = '0;

    logic       done1, plot1, done2, plot2;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [2:0] col1, col2;

    int total = 0, bad = 0, sel = 0;
    logic       obs_done, obs_plot;
    logic [8:0] obs_x;
    logic [7:0] obs_y;
    logic [2:0] obs_col;

    circle_draw_param dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .centre_x(cx[7:0]), .centre_y(cy[6:0]), .radius(radius), .colour(colour),
        .done(done1), .vga_x(x1), .vga_y(y1), .vga_colour(col1), .vga_plot(plot1)
    );

    circle_draw_param #(
        .SCREEN_W(320), .SCREEN_H(240), .X_W(9), .Y_W(8), .R_W(8), .COLOUR_W(3)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode),
        .centre_x(cx), .centre_y(cy), .radius(radius), .colour(colour),
        .done(done2), .vga_x(x2), .vga_y(y2), .vga_colour(col2), .vga_plot(plot2)
    );

    always_comb begin
        if (sel == 0) begin
            obs_done = done1; obs_plot = plot1; obs_x = {1'b0, x1};
            obs_y = {1'b0, y1}; obs_col = col1;
        end else begin
            obs_done = done2; obs_plot = plot2; obs_x = x2;
            obs_y = y2; obs_col = col2;
        end
    end

    task automatic launch(input int s, input logic m, input int xc, input int yc,
                          input int r, input int c);
        @(negedge clk);
        sel = s; mode = m; cx = 9'(xc); cy = 8'(yc); radius = 8'(r); colour = 3'(c);
        if (s == 0) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset done1: got %b want 0", done1); end
        total++; if (plot1 !== 1'b0) begin bad++; $display("FAIL reset plot1: got %b want 0", plot1); end
        total++; if (x1 !== 8'd0 || y1 !== 7'd0) begin bad++; $display("FAIL reset xy1: got %0d,%0d want 0,0", x1, y1); end
        total++; if (col1 !== 3'd0) begin bad++; $display("FAIL reset col1: got %0d want 0", col1); end
        total++; if (done2 !== 1'b0 || plot2 !== 1'b0) begin bad++; $display("FAIL reset dut2: got done=%b plot=%b want 0,0", done2, plot2); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_outline_r0();
        launch(0, 1'b0, 80, 60, 0, 5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (plot1 !== 1'b1 || x1 !== 8'd80 || y1 !== 7'd60 || col1 !== 3'd5) begin
                bad++;
                $display("FAIL r0 px%0d: got plot=%b (%0d,%0d) c=%0d want plot=1 (80,60) c=5", i, plot1, x1, y1, col1);
            end
        end
        @(negedge clk);
        total++;
        if (done1 !== 1'b1 || plot1 !== 1'b0) begin
            bad++; $display("FAIL r0 done: got done=%b plot=%b want 1,0", done1, plot1);
        end
    endtask

    // Entered with start1 still high and the engine in DONE
    task automatic test_done_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (done1 !== 1'b1 || plot1 !== 1'b0) begin
                bad++; $display("FAIL hold cyc%0d: got done=%b plot=%b want 1,0", i, done1, plot1);
            end
        end
        start1 = 1'b0;
        @(negedge clk);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL hold release: got done=%b want 0", done1); end
    endtask

    task automatic test_filled_r1();
        int fx [20] = '{9,10,11, 9,10,11, 10,10, 9,10,11, 9,10,11, 9,10,11, 9,10,11};
        int fy [20] = '{10,10,10, 10,10,10, 11,9, 11,11,11, 9,9,9, 11,11,11, 9,9,9};
        launch(0, 1'b1, 10, 10, 1, 4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (plot1 !== 1'b1 || x1 !== 8'(fx[i]) || y1 !== 7'(fy[i]) || col1 !== 3'd4) begin
                bad++;
                $display("FAIL fill_r1 px%0d: got plot=%b (%0d,%0d) c=%0d want plot=1 (%0d,%0d) c=4",
                         i, plot1, x1, y1, col1, fx[i], fy[i]);
            end
        end
        @(negedge clk);
        total++; if (done1 !== 1'b1 || plot1 !== 1'b0) begin bad++; $display("FAIL fill_r1 done: got done=%b plot=%b want 1,0", done1, plot1); end
        start1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_filled_r0_corner();
        launch(0, 1'b1, 159, 119, 0, 7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (plot1 !== 1'b1 || x1 !== 8'd159 || y1 !== 7'd119 || col1 !== 3'd7) begin
                bad++; $display("FAIL fill_r0 px%0d: got plot=%b (%0d,%0d) want plot=1 (159,119)", i, plot1, x1, y1);
            end
        end
        @(negedge clk);
        total++; if (done1 !== 1'b1 || plot1 !== 1'b0) begin bad++; $display("FAIL fill_r0 done: got done=%b plot=%b want 1,0", done1, plot1); end
        start1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_outline(input string tag, input int s, input int xc, input int yc,
                                input int r, input int c, input int w, input int h);
        int ox, oy, crit, ex, ey, n;
        logic exp_in;
        bit run;
        launch(s, 1'b0, xc, yc, r, c);
        ox = r; oy = 0; crit = 1 - r; run = 1'b1; n = 0;
        while (run) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin ex = xc + ox; ey = yc + oy; end
                    1: begin ex = xc + oy; ey = yc + ox; end
                    2: begin ex = xc - ox; ey = yc + oy; end
                    3: begin ex = xc - oy; ey = yc + ox; end
                    4: begin ex = xc - ox; ey = yc - oy; end
                    5: begin ex = xc - oy; ey = yc - ox; end
                    6: begin ex = xc + ox; ey = yc - oy; end
                    default: begin ex = xc + oy; ey = yc - ox; end
                endcase
                exp_in = (ex >= 0 && ex < w && ey >= 0 && ey < h);
                @(negedge clk);
                total++;
                if (obs_plot !== exp_in) begin
                    bad++; $display("FAIL %s plot px%0d: got %b want %b at (%0d,%0d)", tag, n, obs_plot, exp_in, ex, ey);
                end
                if (exp_in) begin
                    total++;
                    if (obs_x !== 9'(ex) || obs_y !== 8'(ey) || obs_col !== 3'(c)) begin
                        bad++;
                        $display("FAIL %s px%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d", tag, n, obs_x, obs_y, obs_col, ex, ey, c);
                    end
                end
                n++;
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin ox--; crit += 2 * (oy - ox) + 1; end
            run = (oy <= ox);
        end
        @(negedge clk);
        total++; if (obs_done !== 1'b1 || obs_plot !== 1'b0) begin bad++; $display("FAIL %s done after %0d px: got done=%b plot=%b want 1,0", tag, n, obs_done, obs_plot); end
        start1 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL %s release: got done=%b want 0", tag, obs_done); end
    endtask

    task automatic test_reset_mid_draw();
        launch(0, 1'b0, 80, 60, 40, 2);
        repeat (20) @(negedge clk);
        rst = 1'b1; start1 = 1'b0;
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || plot1 !== 1'b0 || x1 !== 8'd0 || y1 !== 7'd0 || col1 !== 3'd0) begin
            bad++; $display("FAIL midreset: got done=%b plot=%b (%0d,%0d) c=%0d want all 0", done1, plot1, x1, y1, col1);
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (plot1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL midreset idle: got plot=%b done=%b want 0,0", plot1, done1); end
        test_outline("redraw_r40", 0, 80, 60, 40, 2, 160, 120);
    endtask

    initial begin
        test_reset();
        test_outline_r0();
        test_done_hold();
        test_filled_r1();
        test_filled_r0_corner();
        test_outline("r40", 0, 80, 60, 40, 2, 160, 120);
        test_outline("clip_origin", 0, 0, 0, 10, 7, 160, 120);
        test_outline("clip_corner", 0, 159, 119, 3, 1, 160, 120);
        test_reset_mid_draw();
        test_outline("wide_screen", 1, 300, 200, 30, 6, 320, 240);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
